pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  Generates per-stage load and flush controls from instruction-fetch and data-memory handshakes,
//  load-use hazards and MEM-stage branch redirects.
//  Tracks outstanding dmem accesses in a small FSM, detects dmem timeouts and latches pending redirects.
// PARAMETERS
//  DMEM_TIMEOUT  255  cycles in D_WAIT before dmem_timeout sets (1..2^TO_W-1)
//  TO_W          8    width of the timeout counter
//  CNT_W         32   width of the perf counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      asynchronous, active-low reset
//  imem_resp      in   1      fetch data valid this cycle
//  dmem_req       in   1      MEM stage holds a load or store (ctrl_mem qualified)
//  dmem_resp      in   1      dmem access completes this cycle
//  ex_is_load     in   1      EX-stage instruction is a load
//  ex_rd          in   5      EX-stage destination register
//  id_rs1         in   5      ID-stage source register 1
//  id_rs2         in   5      ID-stage source register 2
//  br_taken_mem   in   1      MEM-stage branch/jump redirect (br_en_mem or jal/jalr)
//  load_pc        out  1      PC register load
//  load_if_id     out  1      IF/ID load
//  load_id_ex     out  1      ID/EX load
//  load_ex_mem    out  1      EX/MEM load
//  load_mem_wb    out  1      MEM/WB load
//  flush_if_id    out  1      IF/ID captures a bubble (valid only with its load)
//  flush_id_ex    out  1      ID/EX captures a bubble
//  flush_ex_mem   out  1      EX/MEM captures a bubble
//  dmem_timeout   out  1      sticky error flag
//  stall_cycles   out  CNT_W  cycles with any stall
//  flush_events   out  CNT_W  count of redirect flushes
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - FSM=D_IDLE; redirect_pend=0; timeout counter=0; dmem_timeout=0; counters=0.
//    - All load_*/flush_* outputs=0 while rst is low.
//  - dmem FSM: D_IDLE -> D_WAIT when dmem_req & ~dmem_resp. D_WAIT -> D_IDLE on dmem_resp.
//    - dmem_req & dmem_resp in D_IDLE: zero-stall access; FSM stays in D_IDLE.
//  - dstall = (D_IDLE & dmem_req & ~dmem_resp) | (D_WAIT & ~dmem_resp).
//  - istall = ~imem_resp.
//  - luh = ex_is_load & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  - Priority, evaluated combinationally each cycle:
//    1. dstall: all load_*=0, all flush_*=0 (full freeze). Any redirect is held by its stage.
//    2. br_taken_mem:
//       - load_pc=1, all stage loads=1, flush_if_id=flush_id_ex=flush_ex_mem=1.
//       - If also istall: load_pc=1, load_if_id=0, and redirect_pend<=1.
//    3. redirect_pend & imem_resp: load_if_id=1, flush_if_id=1 (discard wrong-path fetch),
//       load_pc=1, downstream loads=1, redirect_pend<=0.
//    4. luh: load_pc=0, load_if_id=0, load_id_ex=1 with flush_id_ex=1; EX/MEM and MEM/WB load.
//    5. istall: load_pc=0, load_if_id=0, ID/EX loads a bubble, EX/MEM and MEM/WB load.
//    6. else: all loads=1, all flushes=0.
//  - redirect_pend holds through dstall. A second br_taken_mem while pending keeps it set.
//  - Timeout: counter increments each D_WAIT cycle and clears on D_IDLE.
//    - Reaching DMEM_TIMEOUT sets dmem_timeout; it stays set until reset. Counter saturates.
//  - Reset mid-D_WAIT: FSM returns to D_IDLE; the in-flight response is the memory side's concern.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    - stall_cycles +1 per cycle with dstall|istall|luh.
//    - flush_events +1 per br_taken_mem not under dstall.
//    - Both counters wrap at 2^CNT_W.
//  PIPE_PERF_CNT_EN undefined: no counter flops; stall_cycles=flush_events='0.
// TESTING
//  1. Reset low 3 cycles with imem_resp=1 -> all loads/flushes 0. After release with no hazards -> all loads 1.
//  2. dmem_req=1, dmem_resp low 4 cycles -> loads 0 for 4 cycles, FSM D_WAIT. Resp cycle -> loads 1, D_IDLE.
//  3. ex_is_load=1, ex_rd=5, id_rs2=5 -> load_pc=0, load_if_id=0, flush_id_ex=1, load_ex_mem=1. ex_rd=0 -> no stall.
//  4. br_taken_mem with imem_resp=0, then imem_resp after 2 cycles -> flush_if_id=1 on the resp cycle, redirect_pend clears.
//  5. DMEM_TIMEOUT=4, dmem_resp never -> dmem_timeout=1 after 4 D_WAIT cycles; still 1 after later resp, until reset.
//  6. PIPE_PERF_CNT_EN: 3 luh cycles + 1 branch -> stall_cycles=3, flush_events=1. Undefined -> both 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage load/flush controls, dmem wait FSM, timeout flag, redirect latch.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             br_taken_mem,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {D_IDLE, D_WAIT} dstate_t;

  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(DMEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DMEM_TIMEOUT - 1);

  dstate_t         state, state_nxt;
  logic            redirect_pend, pend_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            dstall, istall, luh;

  assign dstall = ((state == D_IDLE) && dmem_req && !dmem_resp) ||
                  ((state == D_WAIT) && !dmem_resp);
  assign istall = !imem_resp;
  assign luh    = ex_is_load && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= D_IDLE;
      redirect_pend <= 1'b0;
    end else begin
      state         <= state_nxt;
      redirect_pend <= pend_nxt;
    end
  end

  // Next state and priority-ordered stage controls
  always_comb begin
    state_nxt    = state;
    pend_nxt     = redirect_pend;
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    if (state == D_IDLE) begin
      if (dmem_req && !dmem_resp) state_nxt = D_WAIT;
    end else begin
      if (dmem_resp) state_nxt = D_IDLE;
    end

    if (dstall) begin
      pend_nxt = redirect_pend;
    end else if (br_taken_mem) begin
      load_pc      = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      // A stalled fetch cannot take the bubble now; remember to discard it on arrival
      load_if_id   = !istall;
      flush_if_id  = !istall;
      if (istall || redirect_pend) pend_nxt = 1'b1;
    end else if (redirect_pend && imem_resp) begin
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      flush_if_id  = 1'b1;
      pend_nxt     = 1'b0;
    end else if (luh || istall) begin
      load_id_ex   = 1'b1;
      flush_id_ex  = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
    end else begin
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
    end

    if (!rst) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
    end
  end

  // Saturating wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt       <= '0;
      dmem_timeout <= 1'b0;
    end else if (state == D_WAIT) begin
      if (to_cnt != TO_LIM) to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_LAST) dmem_timeout <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (dstall || istall || luh) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_taken_mem && !dstall) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
